mailbox_ingress_arbiter: RTL and testbench
==========================================

Name: mailbox_ingress_arbiter

Overview:
Registered arbiter that shares the single mailbox ingress port between two producers: the loopback path (self-addressed messages from the post office) and the communication-interface receive path. It sits between the loopback interceptor and the mailbox. It replaces fixed loopback-first priority with bounded-burst priority, so network traffic cannot be starved. It provides one output register stage with full throughput and per-source transfer counters for debug.

Parameters:
MAX_LOOPBACK_BURST, 4, max consecutive loopback grants while the network is waiting; 0 means the network always wins contention; legal range 0..15
COUNTER_WIDTH, 16, width of the per-source transfer counters

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
loopback_valid_i  in  1  loopback message available
loopback_ready_o  out  1  loopback message accepted this cycle
loopback_data_i  in  interface_receive_data_t  loopback message
network_valid_i  in  1  network message available
network_ready_o  out  1  network message accepted this cycle
network_data_i  in  interface_receive_data_t  network message
mailbox_valid_o  out  1  registered message to mailbox
mailbox_ready_i  in  1  mailbox accepts
mailbox_data_o  out  interface_receive_data_t  registered message
loopback_count_o  out  COUNTER_WIDTH  loopback transfers accepted (wrapping)
network_count_o  out  COUNTER_WIDTH  network transfers accepted (wrapping)

Behaviour:
- Reset (rstn_i low at a clk_i edge): mailbox_valid_o=0, mailbox_data_o='0, burst_cnt=0, both counters=0. Ready outputs are combinational; during reset they are forced to 0.
- Any message held in the output register is discarded on reset. Upstream must keep valid asserted until ready, so no input message is lost.
- can_load = !mailbox_valid_o | mailbox_ready_i. This is a combinational path from mailbox_ready_i to the source readys; it is intentional and gives 1 transfer/cycle.
- Grant (combinational):
  - only loopback valid -> loopback
  - only network valid -> network
  - both valid -> loopback if burst_cnt < MAX_LOOPBACK_BURST, else network
  - neither valid -> none
- loopback_ready_o = can_load & grant==loopback. network_ready_o = can_load & grant==network. At most one ready is high per cycle.
- A transfer occurs when a source's valid and ready are both high. On the following edge: mailbox_valid_o=1, mailbox_data_o=that source's data, and that source's counter increments, wrapping modulo 2^COUNTER_WIDTH.
- If mailbox_valid_o & mailbox_ready_i and no transfer occurs: mailbox_valid_o=0 next cycle. mailbox_data_o holds its value.
- If mailbox_valid_o & !mailbox_ready_i: output valid and data are held stable, and both source readys are 0.
- Latency: input acceptance -> mailbox_valid_o is 1 cycle. Back-to-back transfers sustain 1 per cycle while mailbox_ready_i=1.
- burst_cnt (width 4) update, evaluated on each edge:
  - network transfer -> 0
  - else network_valid_i=0 -> 0
  - else loopback transfer -> burst_cnt+1, saturating at MAX_LOOPBACK_BURST
  - else hold
- Fairness guarantee: with both sources continuously valid and mailbox_ready_i=1, the grant sequence is MAX_LOOPBACK_BURST loopback transfers, then 1 network transfer, repeating. With MAX_LOOPBACK_BURST=0 it is network-only until the network deasserts.
- Data is never modified. The ungranted source sees ready=0 and must hold its valid and data (standard valid/ready).
- No combinational path from the valid inputs to mailbox_valid_o or mailbox_data_o.

Test Plan:
- Reset, then idle: rstn_i low 2 cycles, no valids -> mailbox_valid_o=0, both readys 0, counters 0; no output activity for 10 cycles.
- Single source streaming: network_valid_i=1 with data D0..D7, mailbox_ready_i=1 -> network_ready_o=1 every cycle; mailbox_data_o=D0..D7 on consecutive cycles, starting 1 cycle after the first acceptance; network_count_o=8.
- Contention, MAX_LOOPBACK_BURST=4: both valid continuously for 20 transfers, mailbox_ready_i=1 -> output source pattern LLLLN repeated 4 times; loopback_count_o=16, network_count_o=4.
- Backpressure: output valid, mailbox_ready_i=0 for 5 cycles with both sources valid -> mailbox_data_o stable, both readys 0. On ready=1, the held item drains and a new item is accepted in the same cycle; no bubble and no duplicate.
- Contention, MAX_LOOPBACK_BURST=0: both valid for 3 cycles -> network granted all 3 cycles. Network then drops valid -> loopback granted the next cycle and burst_cnt stays 0.
- Reset mid-operation: output valid and loopback valid, assert rstn_i low 1 cycle -> mailbox_valid_o=0 and counters=0 after the edge. After release the loopback message is accepted again and output exactly once; loopback_count_o=1.

Source files
------------

// File: rtl/mailbox_ingress_arbiter_if.sv
// Handshake bundle around the mailbox ingress arbiter.
//   loopback_*  : valid/ready/data from the loopback interceptor
//   network_*   : valid/ready/data from the communication-interface receive path
//   mailbox_*   : registered valid/ready/data towards the mailbox
// Modports:
//   slave  - the arbiter's view (consumes both sources, drives the mailbox side)
//   master - the surrounding environment's view (drives the sources, sinks the mailbox side)
interface mailbox_ingress_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  loopback_valid_i;
  logic                  loopback_ready_o;
  logic [DATA_WIDTH-1:0] loopback_data_i;
  logic                  network_valid_i;
  logic                  network_ready_o;
  logic [DATA_WIDTH-1:0] network_data_i;
  logic                  mailbox_valid_o;
  logic                  mailbox_ready_i;
  logic [DATA_WIDTH-1:0] mailbox_data_o;

  modport slave (
    input  loopback_valid_i, loopback_data_i,
    output loopback_ready_o,
    input  network_valid_i, network_data_i,
    output network_ready_o,
    output mailbox_valid_o, mailbox_data_o,
    input  mailbox_ready_i
  );

  modport master (
    output loopback_valid_i, loopback_data_i,
    input  loopback_ready_o,
    output network_valid_i, network_data_i,
    input  network_ready_o,
    input  mailbox_valid_o, mailbox_data_o,
    output mailbox_ready_i
  );
endinterface

// File: rtl/mailbox_ingress_arbiter.sv
// Shares the single mailbox ingress port between the loopback path and the
// network receive path. One output register stage with full throughput.
// Loopback wins contention for at most MAX_LOOPBACK_BURST consecutive grants
// while the network is waiting, then the network gets one grant.
// Ports:
//   clk_i            - clock
//   rstn_i           - synchronous active-low reset
//   bus              - handshake bundle (slave modport): loopback, network, mailbox
//   loopback_count_o - wrapping count of accepted loopback transfers
//   network_count_o  - wrapping count of accepted network transfers
module mailbox_ingress_arbiter #(
  parameter int unsigned MAX_LOOPBACK_BURST = 4,
  parameter int unsigned COUNTER_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH         = 32
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  mailbox_ingress_arbiter_if.slave bus,
  output logic [COUNTER_WIDTH-1:0] loopback_count_o,
  output logic [COUNTER_WIDTH-1:0] network_count_o
);

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_LOOPBACK,
    GRANT_NETWORK
  } grant_e;

  localparam logic [3:0] MAX_BURST = 4'(MAX_LOOPBACK_BURST);

  grant_e     grant;
  logic       can_load;
  logic       loopback_xfer;
  logic       network_xfer;
  logic [3:0] burst_cnt;

  always_comb begin
    grant = GRANT_NONE;
    if (bus.loopback_valid_i && bus.network_valid_i) begin
      grant = (burst_cnt < MAX_BURST) ? GRANT_LOOPBACK : GRANT_NETWORK;
    end else if (bus.loopback_valid_i) begin
      grant = GRANT_LOOPBACK;
    end else if (bus.network_valid_i) begin
      grant = GRANT_NETWORK;
    end
  end

  // mailbox_ready_i feeds the source readys combinationally so a drain and a
  // new load can share one cycle.
  always_comb begin
    can_load             = !bus.mailbox_valid_o || bus.mailbox_ready_i;
    bus.loopback_ready_o = rstn_i && can_load && (grant == GRANT_LOOPBACK);
    bus.network_ready_o  = rstn_i && can_load && (grant == GRANT_NETWORK);
    loopback_xfer        = bus.loopback_valid_i && bus.loopback_ready_o;
    network_xfer         = bus.network_valid_i && bus.network_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      bus.mailbox_valid_o <= 1'b0;
      bus.mailbox_data_o  <= '0;
      loopback_count_o    <= '0;
      network_count_o     <= '0;
    end else begin
      if (loopback_xfer) begin
        bus.mailbox_valid_o <= 1'b1;
        bus.mailbox_data_o  <= bus.loopback_data_i;
        loopback_count_o    <= loopback_count_o + COUNTER_WIDTH'(1);
      end else if (network_xfer) begin
        bus.mailbox_valid_o <= 1'b1;
        bus.mailbox_data_o  <= bus.network_data_i;
        network_count_o     <= network_count_o + COUNTER_WIDTH'(1);
      end else if (bus.mailbox_ready_i) begin
        // Drained with nothing to replace it; data is left as-is.
        bus.mailbox_valid_o <= 1'b0;
      end
    end
  end

  // Consecutive loopback grants while the network is waiting. Cleared as
  // soon as the network is served or stops asking.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      burst_cnt <= '0;
    end else if (network_xfer || !bus.network_valid_i) begin
      burst_cnt <= '0;
    end else if (loopback_xfer && (burst_cnt < MAX_BURST)) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mailbox_ingress_arbiter.sv
module tb_mailbox_ingress_arbiter;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 16;
  localparam int          MAXB = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [CW-1:0] lcnt, ncnt, lcnt0, ncnt0;
  int            n_vec = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  mailbox_ingress_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  mailbox_ingress_arbiter_if #(.DATA_WIDTH(DW)) bus0 ();

  mailbox_ingress_arbiter #(
    .MAX_LOOPBACK_BURST(MAXB),
    .COUNTER_WIDTH(CW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .bus(bus),
    .loopback_count_o(lcnt),
    .network_count_o(ncnt)
  );

  mailbox_ingress_arbiter #(
    .MAX_LOOPBACK_BURST(0),
    .COUNTER_WIDTH(CW),
    .DATA_WIDTH(DW)
  ) dut0 (
    .clk_i(clk),
    .rstn_i(rstn),
    .bus(bus0),
    .loopback_count_o(lcnt0),
    .network_count_o(ncnt0)
  );

  typedef struct {
    logic          rstn;
    logic          lv;
    logic [DW-1:0] ld;
    logic          nv;
    logic [DW-1:0] nd;
    logic          mr;
    logic          e_lr;
    logic          e_nr;
    logic          e_mv;
    logic [DW-1:0] e_md;
  } vec_t;

  vec_t tbl [11];

  // random-phase reference model state
  logic          lp, np, mr, can, lwin, elr, enr;
  logic [DW-1:0] ld, nd;
  int            streak, mlc, mnc, li, ni;
  logic [DW-1:0] q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic lv, input logic [DW-1:0] ldat,
                       input logic nv, input logic [DW-1:0] ndat, input logic m);
    rstn                 = r;
    bus.loopback_valid_i = lv;
    bus.loopback_data_i  = ldat;
    bus.network_valid_i  = nv;
    bus.network_data_i   = ndat;
    bus.mailbox_ready_i  = m;
  endtask

  task automatic drive0(input logic lv, input logic [DW-1:0] ldat,
                        input logic nv, input logic [DW-1:0] ndat, input logic m);
    bus0.loopback_valid_i = lv;
    bus0.loopback_data_i  = ldat;
    bus0.network_valid_i  = nv;
    bus0.network_data_i   = ndat;
    bus0.mailbox_ready_i  = m;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    drive0(1'b0, '0, 1'b0, '0, 1'b0);
    advance();
    advance();
  endtask

  initial begin
    // rows: inputs for one cycle, readys expected that cycle, register contents before the edge
    tbl[0]  = '{1'b0, 1'b1, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'hA000_0001, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hB000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0001};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hB000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA000_0001};
    tbl[4]  = '{1'b1, 1'b1, 32'hA000_0002, 1'b1, 32'hB000_0002, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB000_0001};
    tbl[5]  = '{1'b1, 1'b1, 32'hA000_0003, 1'b1, 32'hB000_0002, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0002};
    tbl[6]  = '{1'b1, 1'b1, 32'hA000_0004, 1'b1, 32'hB000_0002, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0003};
    tbl[7]  = '{1'b1, 1'b1, 32'hA000_0005, 1'b1, 32'hB000_0002, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0004};
    tbl[8]  = '{1'b1, 1'b1, 32'hA000_0006, 1'b1, 32'hB000_0002, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA000_0005};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hB000_0002};
    tbl[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hB000_0002};

    // reset, then idle
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    drive0(1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_lr", bus.loopback_ready_o, 1'b0);
      chk("rst_nr", bus.network_ready_o, 1'b0);
      advance();
    end
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("idle_mv", bus.mailbox_valid_o, 1'b0);
      chk("idle_lr", bus.loopback_ready_o, 1'b0);
      chk("idle_nr", bus.network_ready_o, 1'b0);
      advance();
    end
    chk("idle_md", bus.mailbox_data_o, 32'h0);
    chk("idle_lcnt", lcnt, 16'd0);
    chk("idle_ncnt", ncnt, 16'd0);

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rstn, tbl[i].lv, tbl[i].ld, tbl[i].nv, tbl[i].nd, tbl[i].mr);
      settle();
      chk("tbl_lr", bus.loopback_ready_o, tbl[i].e_lr);
      chk("tbl_nr", bus.network_ready_o, tbl[i].e_nr);
      chk("tbl_mv", bus.mailbox_valid_o, tbl[i].e_mv);
      chk("tbl_md", bus.mailbox_data_o, tbl[i].e_md);
      advance();
    end
    chk("tbl_lcnt", lcnt, 16'd5);
    chk("tbl_ncnt", ncnt, 16'd2);

    // network streaming D0..D7
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b0, '0, k < 8, 32'hD0 + k, 1'b1);
      settle();
      if (k < 8) chk("strm_nr", bus.network_ready_o, 1'b1);
      if (k > 0) begin
        chk("strm_mv", bus.mailbox_valid_o, 1'b1);
        chk("strm_md", bus.mailbox_data_o, 32'hD0 + k - 1);
      end
      advance();
    end
    chk("strm_ncnt", ncnt, 16'd8);

    // contention with MAX_LOOPBACK_BURST=4: LLLLN x4
    do_reset();
    li = 0;
    ni = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 32'h1000 + li, 1'b1, 32'h2000 + ni, 1'b1);
      settle();
      chk("cont_lr", bus.loopback_ready_o, (i % 5) != 4);
      chk("cont_nr", bus.network_ready_o, (i % 5) == 4);
      if (bus.loopback_ready_o) li++;
      if (bus.network_ready_o) ni++;
      advance();
    end
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    settle();
    chk("cont_lcnt", lcnt, 16'd16);
    chk("cont_ncnt", ncnt, 16'd4);
    chk("cont_md", bus.mailbox_data_o, 32'h2003);
    advance();

    // backpressure: hold 5 cycles, then drain and load in the same cycle
    do_reset();
    drive(1'b1, 1'b1, 32'hC0, 1'b1, 32'hE0, 1'b0);
    settle();
    chk("bp_lr0", bus.loopback_ready_o, 1'b1);
    advance();
    drive(1'b1, 1'b1, 32'hC1, 1'b1, 32'hE0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_lr", bus.loopback_ready_o, 1'b0);
      chk("bp_nr", bus.network_ready_o, 1'b0);
      chk("bp_mv", bus.mailbox_valid_o, 1'b1);
      chk("bp_md", bus.mailbox_data_o, 32'hC0);
      advance();
    end
    drive(1'b1, 1'b1, 32'hC1, 1'b1, 32'hE0, 1'b1);
    settle();
    chk("bp_rel_lr", bus.loopback_ready_o, 1'b1);
    chk("bp_rel_md", bus.mailbox_data_o, 32'hC0);
    advance();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    settle();
    chk("bp_new_mv", bus.mailbox_valid_o, 1'b1);
    chk("bp_new_md", bus.mailbox_data_o, 32'hC1);
    advance();
    settle();
    chk("bp_dup_mv", bus.mailbox_valid_o, 1'b0);
    chk("bp_lcnt", lcnt, 16'd2);
    advance();

    // MAX_LOOPBACK_BURST=0 instance
    do_reset();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 32'hAA00, 1'b1, 32'hBB00 + i, 1'b1);
      settle();
      chk("m0_nr", bus0.network_ready_o, 1'b1);
      chk("m0_lr", bus0.loopback_ready_o, 1'b0);
      advance();
    end
    drive0(1'b1, 32'hAA00, 1'b0, '0, 1'b1);
    settle();
    chk("m0_drop_lr", bus0.loopback_ready_o, 1'b1);
    advance();
    drive0(1'b1, 32'hAA01, 1'b1, 32'hBB03, 1'b1);
    settle();
    chk("m0_again_nr", bus0.network_ready_o, 1'b1);
    chk("m0_again_lr", bus0.loopback_ready_o, 1'b0);
    chk("m0_md", bus0.mailbox_data_o, 32'hAA00);
    advance();
    drive0(1'b0, '0, 1'b0, '0, 1'b1);
    settle();
    chk("m0_md2", bus0.mailbox_data_o, 32'hBB03);
    chk("m0_lcnt", lcnt0, 16'd1);
    chk("m0_ncnt", ncnt0, 16'd4);
    advance();

    // reset mid-operation
    do_reset();
    drive(1'b1, 1'b1, 32'hF0, 1'b0, '0, 1'b0);
    settle();
    chk("mr_lr0", bus.loopback_ready_o, 1'b1);
    advance();
    drive(1'b0, 1'b1, 32'hF1, 1'b0, '0, 1'b0);
    settle();
    chk("mr_mv_pre", bus.mailbox_valid_o, 1'b1);
    chk("mr_lr_rst", bus.loopback_ready_o, 1'b0);
    advance();
    drive(1'b1, 1'b1, 32'hF1, 1'b0, '0, 1'b1);
    settle();
    chk("mr_mv_post", bus.mailbox_valid_o, 1'b0);
    chk("mr_lcnt0", lcnt, 16'd0);
    chk("mr_lr", bus.loopback_ready_o, 1'b1);
    advance();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    settle();
    chk("mr_mv1", bus.mailbox_valid_o, 1'b1);
    chk("mr_md1", bus.mailbox_data_o, 32'hF1);
    chk("mr_lcnt1", lcnt, 16'd1);
    advance();
    settle();
    chk("mr_once", bus.mailbox_valid_o, 1'b0);
    advance();

    // randomized traffic against reference model
    do_reset();
    lp = 1'b0;
    np = 1'b0;
    streak = 0;
    mlc = 0;
    mnc = 0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      if (!lp) begin
        lp = ($urandom_range(0, 3) != 0);
        ld = $urandom;
      end
      if (!np) begin
        np = ($urandom_range(0, 3) != 0);
        nd = $urandom;
      end
      mr = ($urandom_range(0, 3) != 0);
      drive(1'b1, lp, ld, np, nd, mr);
      settle();
      can  = (q.size() == 0) || mr;
      lwin = (lp && np) ? (streak < MAXB) : lp;
      elr  = can && lp && lwin;
      enr  = can && np && !lwin;
      chk("rnd_lr", bus.loopback_ready_o, elr);
      chk("rnd_nr", bus.network_ready_o, enr);
      chk("rnd_mv", bus.mailbox_valid_o, q.size() != 0);
      if (q.size() != 0) chk("rnd_md", bus.mailbox_data_o, q[0]);
      if (q.size() != 0 && mr) void'(q.pop_front());
      if (!np || enr) streak = 0;
      else if (elr && streak < MAXB) streak++;
      if (elr) begin
        q.push_back(ld);
        mlc++;
        lp = 1'b0;
      end
      if (enr) begin
        q.push_back(nd);
        mnc++;
        np = 1'b0;
      end
      advance();
    end
    chk("rnd_lcnt", lcnt, CW'(mlc));
    chk("rnd_ncnt", ncnt, CW'(mnc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
